// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array result path.
//   N_PE    : accumulators captured per tile (4x4 array)
//   ACC_W   : accumulator width coming out of the array
//   OUT_W   : streamed word width after requantisation
//   IDX_W   : width of the row-major accumulator index
//   SHIFT_W : width of the requantisation right-shift amount
//   drain_state_t : drain FSM states, also used by the array controller
package systolic_pkg;

  localparam int N_PE    = 16;
  localparam int ACC_W   = 32;
  localparam int OUT_W   = 16;
  localparam int IDX_W   = 4;
  localparam int SHIFT_W = 5;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } drain_state_t;

endpackage

// File: rtl/drain_requant.sv
// Combinational requantiser: unsigned right shift followed by saturation
// to OUT_W bits. Intended for reuse by later pooling/activation stages.
//   acc_i   in  ACC_W    unsigned accumulator value
//   shift_i in  SHIFT_W  right-shift amount
//   data_o  out OUT_W    shifted value, or all ones when it does not fit
//   sat_o   out 1        high when the shifted value was clipped
module drain_requant
  import systolic_pkg::*;
(
  input  logic [ACC_W-1:0]   acc_i,
  input  logic [SHIFT_W-1:0] shift_i,
  output logic [OUT_W-1:0]   data_o,
  output logic               sat_o
);

  logic [ACC_W-1:0] shifted;

  // A logical shift by ACC_W or more yields zero, so over-range shift
  // amounts need no separate handling.
  always_comb begin
    shifted = acc_i >> shift_i;
    sat_o   = |shifted[ACC_W-1:OUT_W];
    data_o  = sat_o ? {OUT_W{1'b1}} : shifted[OUT_W-1:0];
  end

endmodule

// File: rtl/systolic_result_drain.sv
// Result drain for the 4x4 PE accumulator array.
// Snapshots all accumulators on a capture handshake, pulses acc_clr for one
// cycle so the array can start the next tile, then streams the snapshot out
// row-major (index 0..15), one requantised word per accepted beat.
//
// Handshakes (both channels): a transfer happens on a rising clk edge where
// valid and ready are both high. The producer holds valid and its payload
// stable until that edge; ready may change freely.
//   capture channel : cap_valid (controller) / cap_ready (this block)
//   output channel  : out_valid (this block) / out_ready (sink)
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   acc_in[0:15]      accumulator values from the array
//   cap_valid/ready   capture handshake; cap_ready high only in IDLE
//   shift             right-shift amount, sampled at capture
//   acc_clr           one-cycle pulse in the cycle after a capture
//   out_valid/ready   output handshake
//   out_data          requantised word
//   out_idx           accumulator index of current word
//   out_last          high with index 15
//   out_sat           current word was clipped
//   busy              high while streaming
//   dbg_state         current FSM state (drain_state_t encoding)
module systolic_result_drain
  import systolic_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [ACC_W-1:0]   acc_in [0:N_PE-1],
  input  logic               cap_valid,
  output logic               cap_ready,
  input  logic [SHIFT_W-1:0] shift,
  output logic               acc_clr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic [IDX_W-1:0]   out_idx,
  output logic               out_last,
  output logic               out_sat,
  output logic               busy,
  output logic               dbg_state
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PE - 1);

  drain_state_t       state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   idx_d;
  logic [SHIFT_W-1:0] shift_q;
  logic               acc_clr_q;
  logic [ACC_W-1:0]   buf_q [0:N_PE-1];

  logic cap_hs;
  logic out_hs;

  assign cap_hs = cap_valid && cap_ready;
  assign out_hs = out_valid && out_ready;
  assign idx_d  = idx_q + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      shift_q   <= '0;
      acc_clr_q <= 1'b0;
      for (int i = 0; i < N_PE; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      // acc_clr is a single-cycle pulse: cleared every cycle unless a
      // capture happens on this edge.
      acc_clr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cap_hs) begin
            state_q   <= STREAM;
            idx_q     <= '0;
            shift_q   <= shift;
            acc_clr_q <= 1'b1;
            for (int i = 0; i < N_PE; i++) begin
              buf_q[i] <= acc_in[i];
            end
          end
        end
        STREAM: begin
          if (out_hs) begin
            if (idx_q == LAST_IDX) begin
              state_q <= IDLE;
              idx_q   <= '0;
            end else begin
              idx_q <= idx_d;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          idx_q   <= '0;
        end
      endcase
    end
  end

  // Payload comes straight from registered state, so it holds while the
  // sink stalls without any extra output registers.
  drain_requant u_requant (
    .acc_i   (buf_q[idx_q]),
    .shift_i (shift_q),
    .data_o  (out_data),
    .sat_o   (out_sat)
  );

  assign out_valid = (state_q == STREAM);
  assign busy      = (state_q == STREAM);
  assign cap_ready = (state_q == IDLE);
  assign acc_clr   = acc_clr_q;
  assign out_idx   = idx_q;
  assign out_last  = (state_q == STREAM) && (idx_q == LAST_IDX);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed testbench for systolic_result_drain.
module tb_systolic_result_drain;
  import systolic_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [ACC_W-1:0]   acc_in [0:N_PE-1];
  logic               cap_valid;
  logic               cap_ready;
  logic [SHIFT_W-1:0] shift;
  logic               acc_clr;
  logic               out_valid;
  logic               out_ready;
  logic [OUT_W-1:0]   out_data;
  logic [IDX_W-1:0]   out_idx;
  logic               out_last;
  logic               out_sat;
  logic               busy;
  logic               dbg_state;

  systolic_result_drain dut (
    .clk       (clk),
    .rst       (rst),
    .acc_in    (acc_in),
    .cap_valid (cap_valid),
    .cap_ready (cap_ready),
    .shift     (shift),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_sat   (out_sat),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  // entry = {idx[3:0], sat, data[15:0]}
  logic [20:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // All sampling and driving happens 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int idx, input logic [15:0] d, input logic s);
    logic [3:0] i4;
    i4 = idx[3:0];
    exp_q.push_back({i4, s, d});
  endtask

  task automatic capture(input logic [4:0] sh, input string tag);
    int w;
    w = 0;
    shift     = sh;
    cap_valid = 1'b1;
    while (!cap_ready && w < 50) begin
      tick();
      w++;
    end
    chk({tag, "_cap_ready"}, {31'b0, cap_ready}, 32'd1);
    tick();
    cap_valid = 1'b0;
    chk({tag, "_acc_clr_first"}, {31'b0, acc_clr}, 32'd1);
    chk({tag, "_valid_first"}, {31'b0, out_valid}, 32'd1);
  endtask

  // pat 0: out_ready always high; pat 1: out_ready 1,0,0 repeating.
  task automatic run_stream(input int pat, input string tag, output int cycles);
    int k;
    logic [20:0] e;
    k = 0;
    while (exp_q.size() > 0 && k < 200) begin
      out_ready = (pat == 0) ? 1'b1 : ((k % 3) == 0);
      chk({tag, "_acc_clr"}, {31'b0, acc_clr}, (k == 0) ? 32'd1 : 32'd0);
      chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
      if (out_valid) begin
        e = exp_q[0];
        chk({tag, "_data"}, {16'b0, out_data}, {16'b0, e[15:0]});
        chk({tag, "_sat"}, {31'b0, out_sat}, {31'b0, e[16]});
        chk({tag, "_idx"}, {28'b0, out_idx}, {28'b0, e[20:17]});
        chk({tag, "_last"}, {31'b0, out_last}, (e[20:17] == 4'd15) ? 32'd1 : 32'd0);
        if (out_ready) void'(exp_q.pop_front());
      end
      tick();
      k++;
    end
    cycles = k;
    chk({tag, "_left_in_queue"}, exp_q.size(), 32'd0);
    exp_q.delete();
    chk({tag, "_idle_after"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_cap_ready_after"}, {31'b0, cap_ready}, 32'd1);
    out_ready = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    int n_cap;
    int n_clr;
    logic [15:0] exp_w3 [0:2];
    logic        exp_s3 [0:2];
    logic [4:0]  sh_tab [0:2];

    rst       = 1'b1;
    cap_valid = 1'b0;
    out_ready = 1'b1;
    shift     = '0;
    for (int i = 0; i < N_PE; i++) acc_in[i] = '0;
    repeat (3) tick();
    rst = 1'b0;

    // reset state
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_cap_ready", {31'b0, cap_ready}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_acc_clr", {31'b0, acc_clr}, 32'd0);
    chk("rst_idx", {28'b0, out_idx}, 32'd0);
    chk("rst_state", {31'b0, dbg_state}, 32'd0);

    // Test 1: acc_in[i]=i*256, shift 8 -> data i, back-to-back beats
    for (int i = 0; i < N_PE; i++) begin
      acc_in[i] = i * 256;
      push(i, 16'(i), 1'b0);
    end
    capture(5'd8, "t1");
    chk("t1_busy", {31'b0, busy}, 32'd1);
    chk("t1_cap_ready_stream", {31'b0, cap_ready}, 32'd0);
    run_stream(0, "t1", cyc);
    chk("t1_beats", cyc, 32'd16);

    // Test 2: saturation and shift boundaries on word 3
    sh_tab[0] = 5'd0;  exp_w3[0] = 16'hFFFF; exp_s3[0] = 1'b1;
    sh_tab[1] = 5'd16; exp_w3[1] = 16'h0123; exp_s3[1] = 1'b0;
    sh_tab[2] = 5'd31; exp_w3[2] = 16'h0000; exp_s3[2] = 1'b0;
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < N_PE; i++) begin
        acc_in[i] = (i == 3) ? 32'h0123_4567 : 32'h0;
        if (i == 3) push(i, exp_w3[t], exp_s3[t]);
        else        push(i, 16'h0, 1'b0);
      end
      capture(sh_tab[t], $sformatf("t2_sh%0d", sh_tab[t]));
      run_stream(0, $sformatf("t2_sh%0d", sh_tab[t]), cyc);
    end

    // Test 3: backpressure, inputs scrambled after capture
    for (int i = 0; i < N_PE; i++) begin
      if (i == 15) begin
        acc_in[i] = 32'hFFFF_FFFF;
        push(i, 16'hFFFF, 1'b1);
      end else begin
        acc_in[i] = (i + 1) * 4096;
        push(i, 16'((i + 1) * 256), 1'b0);
      end
    end
    capture(5'd4, "t3");
    for (int i = 0; i < N_PE; i++) acc_in[i] = 32'hDEAD_0000 + i;
    shift = 5'd0;
    run_stream(1, "t3", cyc);

    // Test 4: cap_valid held high, captures every 17 cycles
    for (int i = 0; i < N_PE; i++) acc_in[i] = i;
    shift     = 5'd0;
    out_ready = 1'b1;
    cap_valid = 1'b1;
    n_cap = 0;
    n_clr = 0;
    for (int c = 0; c < 52; c++) begin
      chk($sformatf("t4_cap_ready_c%0d", c), {31'b0, cap_ready}, ((c % 17) == 0) ? 32'd1 : 32'd0);
      chk($sformatf("t4_acc_clr_c%0d", c), {31'b0, acc_clr}, ((c % 17) == 1) ? 32'd1 : 32'd0);
      chk($sformatf("t4_busy_c%0d", c), {31'b0, busy}, ((c % 17) == 0) ? 32'd0 : 32'd1);
      if (cap_valid && cap_ready) n_cap++;
      if (acc_clr) n_clr++;
      tick();
    end
    cap_valid = 1'b0;
    chk("t4_acc_clr_last", {31'b0, acc_clr}, 32'd1);
    if (acc_clr) n_clr++;
    chk("t4_n_cap", n_cap, 32'd4);
    chk("t4_n_clr", n_clr, 32'd4);
    repeat (16) tick();
    chk("t4_idle_busy", {31'b0, busy}, 32'd0);
    chk("t4_idle_cap_ready", {31'b0, cap_ready}, 32'd1);

    // Test 5: reset at idx 7, then fresh capture
    for (int i = 0; i < N_PE; i++) acc_in[i] = i + 100;
    capture(5'd0, "t5a");
    repeat (7) tick();
    chk("t5_idx_before_rst", {28'b0, out_idx}, 32'd7);
    chk("t5_data_before_rst", {16'b0, out_data}, 32'd107);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("t5_rst_cap_ready", {31'b0, cap_ready}, 32'd1);
    chk("t5_rst_idx", {28'b0, out_idx}, 32'd0);
    chk("t5_rst_acc_clr", {31'b0, acc_clr}, 32'd0);
    for (int i = 0; i < N_PE; i++) begin
      acc_in[i] = i * 3 + 1;
      push(i, 16'(i * 3 + 1), 1'b0);
    end
    capture(5'd0, "t5b");
    run_stream(0, "t5b", cyc);

    // Test 6: capture in the same cycle as reset is ignored
    rst       = 1'b1;
    cap_valid = 1'b1;
    tick();
    rst       = 1'b0;
    cap_valid = 1'b0;
    chk("t6_acc_clr", {31'b0, acc_clr}, 32'd0);
    chk("t6_busy", {31'b0, busy}, 32'd0);
    chk("t6_valid", {31'b0, out_valid}, 32'd0);
    chk("t6_cap_ready", {31'b0, cap_ready}, 32'd1);
    tick();
    chk("t6_acc_clr_next", {31'b0, acc_clr}, 32'd0);
    chk("t6_busy_next", {31'b0, busy}, 32'd0);

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
